// File: rtl/usr_shift_ctrl_if.sv
// -----------------------------------------------------------------------------
// usr_shift_ctrl_if
// Command-side bundle for usr_shift_ctrl: one valid/ready command per
// handshake plus the busy/done status returned to the command source.
//
// Signals:
//   cmd_valid  command present (source -> sequencer)
//   cmd_ready  sequencer idle and able to accept (sequencer -> source)
//   cmd_load   parallel-load cmd_data before shifting
//   cmd_data   load value, WIDTH bits
//   cmd_dir    0 = shift right, 1 = shift left
//   cmd_fill   00 zeros, 01 ones, 10 rotate, 11 arithmetic
//   cmd_amt    number of shift cycles, CNT_W bits
//   busy       high whenever the sequencer is not idle
//   done       one-cycle completion pulse
//
// Modports: master = command source, slave = sequencer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [1:0]       cmd_fill;
  logic [CNT_W-1:0] cmd_amt;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_load, cmd_data, cmd_dir, cmd_fill, cmd_amt,
    input  cmd_ready, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_data, cmd_dir, cmd_fill, cmd_amt,
    output cmd_ready, busy, done
  );
endinterface

// File: rtl/usr_shift_ctrl.sv
// -----------------------------------------------------------------------------
// usr_shift_ctrl
// Command sequencer that owns one universal shift register (USR). Each accepted
// command optionally parallel-loads the USR, then performs cmd_amt shifts in
// the chosen direction with the chosen fill, then pulses done for one cycle.
// USR sel encoding: 00 hold, 01 shift right (MSB_in enters),
//                   10 shift left (LSB_in enters), 11 parallel load.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   cmd_if      command bundle (slave modport of usr_shift_ctrl_if)
//   usr_sel     USR mode select
//   usr_msb_in  serial input entering at the MSB on right shifts
//   usr_lsb_in  serial input entering at the LSB on left shifts
//   usr_i_par   USR parallel-load data (last latched cmd_data)
//   usr_a_par   USR current contents, used for rotate/arithmetic fill
//
// Build option:
//   USR_SHIFT_CTRL_ARITH_EN  when defined, fill 11 on a right shift copies the
//                            sign bit (arithmetic shift); otherwise fill 11 is
//                            treated as zeros in both directions.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module usr_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  usr_shift_ctrl_if.slave  cmd_if,
  output logic [1:0]       usr_sel,
  output logic             usr_msb_in,
  output logic             usr_lsb_in,
  output logic [WIDTH-1:0] usr_i_par,
  input  logic [WIDTH-1:0] usr_a_par
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic [1:0]       r_fill;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_fill;
  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_unused_a;

  // Serial fill bit for the current shift; only the input in use receives it.
  function automatic logic fill_bit(input logic [1:0]       fill,
                                    input logic             dir,
                                    input logic [WIDTH-1:0] a);
    logic b;
    b = 1'b0;
    case (fill)
      2'b01:   b = 1'b1;
      2'b10:   b = dir ? a[WIDTH-1] : a[0];
      2'b11: begin
`ifdef USR_SHIFT_CTRL_ARITH_EN
        // Sign extension only makes sense shifting right; left behaves as zeros.
        b = dir ? 1'b0 : a[WIDTH-1];
`else
        b = 1'b0;
`endif
      end
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign w_accept   = cmd_if.cmd_valid && (r_state == S_IDLE);
  assign w_fill     = fill_bit(r_fill, r_dir, usr_a_par);
  // Only the end bits of A_par feed the fill logic.
  assign w_unused_a = &{1'b0, usr_a_par};

  // State register and latched command fields
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_fill  <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_data <= cmd_if.cmd_data;
        r_dir  <= cmd_if.cmd_dir;
        r_fill <= cmd_if.cmd_fill;
        r_cnt  <= cmd_if.cmd_amt;
      end else if (r_state == S_SHIFT) begin
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next     = r_state;
    w_ready    = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    usr_sel    = 2'b00;
    usr_msb_in = 1'b0;
    usr_lsb_in = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
        if (w_accept) begin
          if (cmd_if.cmd_load)           w_next = S_LOAD;
          else if (cmd_if.cmd_amt != '0) w_next = S_SHIFT;
          else                           w_next = S_DONE;
        end
      end
      S_LOAD: begin
        usr_sel = 2'b11;
        w_next  = (r_cnt != '0) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        usr_sel = r_dir ? 2'b10 : 2'b01;
        if (r_dir) usr_lsb_in = w_fill;
        else       usr_msb_in = w_fill;
        // Counter still holds the remaining shifts including this one.
        if (r_cnt == CNT_W'(1)) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign cmd_if.cmd_ready = w_ready;
  assign cmd_if.busy      = w_busy;
  assign cmd_if.done      = w_done;
  assign usr_i_par        = r_data;

endmodule
